// File: rtl/uart_rx_fifo_if.sv
// Host-side bundle of the receive FIFO: write strobe/data from the uart, read strobe/data and status to the host.
// Error ports exist only when UART_RX_FIFO_ERR_EN is defined.
interface uart_rx_fifo_if #(
  parameter int WIDTH_DATA = 8,
  parameter int DEPTH      = 8
);
  logic                    i_we;
  logic [WIDTH_DATA-1:0]   i_data;
  logic                    i_re;
  logic [WIDTH_DATA-1:0]   o_data;
  logic                    o_rdy;
  logic                    o_mty;
  logic                    o_full;
  logic                    o_afull;
  logic [$clog2(DEPTH):0]  o_cnt;
`ifdef UART_RX_FIFO_ERR_EN
  logic                    i_clr;
  logic                    o_ovf;
  logic                    o_udf;

  modport master (
    output i_we, i_data, i_re, i_clr,
    input  o_data, o_rdy, o_mty, o_full, o_afull, o_cnt, o_ovf, o_udf
  );
  modport slave (
    input  i_we, i_data, i_re, i_clr,
    output o_data, o_rdy, o_mty, o_full, o_afull, o_cnt, o_ovf, o_udf
  );
`else
  modport master (
    output i_we, i_data, i_re,
    input  o_data, o_rdy, o_mty, o_full, o_afull, o_cnt
  );
  modport slave (
    input  i_we, i_data, i_re,
    output o_data, o_rdy, o_mty, o_full, o_afull, o_cnt
  );
`endif
endinterface

// File: rtl/uart_rx_fifo.sv
// Synchronous receive FIFO behind the uart receiver, registered read data and registered status flags.
// Optional sticky overrun/underrun flags with clear input are built when UART_RX_FIFO_ERR_EN is defined.
module uart_rx_fifo #(
  parameter int WIDTH_DATA = 8,
  parameter int DEPTH      = 8,
  parameter int AFULL_LVL  = 6
) (
  input  logic           i_clk,
  input  logic           i_nrst,
  uart_rx_fifo_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL_LVL);

  logic [WIDTH_DATA-1:0] mem [DEPTH];
  logic [AW-1:0]         wp_reg, rp_reg;
  logic [CW-1:0]         cnt_reg, cnt_next;
  logic [WIDTH_DATA-1:0] data_reg;
  logic                  rdy_reg, mty_reg, full_reg, afull_reg;
  logic                  wr_acc, rd_acc;

  // A full FIFO still takes a write when a read frees a slot in the same cycle.
  assign rd_acc   = bus.i_re && !mty_reg;
  assign wr_acc   = bus.i_we && (!full_reg || rd_acc);
  assign cnt_next = cnt_reg + CW'(wr_acc) - CW'(rd_acc);

  always_ff @(posedge i_clk) begin
    if (wr_acc)
      mem[wp_reg] <= bus.i_data;
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      wp_reg    <= '0;
      rp_reg    <= '0;
      cnt_reg   <= '0;
      data_reg  <= '0;
      rdy_reg   <= 1'b0;
      mty_reg   <= 1'b1;
      full_reg  <= 1'b0;
      afull_reg <= 1'b0;
    end else begin
      if (wr_acc)
        wp_reg <= wp_reg + 1'b1;
      if (rd_acc) begin
        rp_reg   <= rp_reg + 1'b1;
        data_reg <= mem[rp_reg];
      end
      rdy_reg   <= rd_acc;
      cnt_reg   <= cnt_next;
      mty_reg   <= (cnt_next == '0);
      full_reg  <= (cnt_next == DEPTH_C);
      afull_reg <= (cnt_next >= AFULL_C);
    end
  end

  assign bus.o_data  = data_reg;
  assign bus.o_rdy   = rdy_reg;
  assign bus.o_mty   = mty_reg;
  assign bus.o_full  = full_reg;
  assign bus.o_afull = afull_reg;
  assign bus.o_cnt   = cnt_reg;

`ifdef UART_RX_FIFO_ERR_EN
  logic ovf_reg, udf_reg;

  // Set beats clear so an error coinciding with i_clr is never lost.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      ovf_reg <= 1'b0;
      udf_reg <= 1'b0;
    end else begin
      if (bus.i_we && !wr_acc)
        ovf_reg <= 1'b1;
      else if (bus.i_clr)
        ovf_reg <= 1'b0;
      if (bus.i_re && mty_reg)
        udf_reg <= 1'b1;
      else if (bus.i_clr)
        udf_reg <= 1'b0;
    end
  end

  assign bus.o_ovf = ovf_reg;
  assign bus.o_udf = udf_reg;
`endif
endmodule
